// File: rtl/boolfn_dec_tree.sv
// Programmable Boolean-function engine: 2-bit decoder tree -> minterm AND-plane -> truth-table OR.
// Optional build macro MINTERM_OUT_EN adds the registered minterm vector output mt_out.
module boolfn_dec_tree #(
    parameter int unsigned             NIN     = 4,
    parameter logic [(1<<NIN)-1:0]     TT_INIT = 16'h0DE0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIN-1:0]      in_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                f_out,
    input  logic                cfg_start,
    input  logic                cfg_bit_valid,
    input  logic                cfg_bit,
    output logic                cfg_busy
`ifdef MINTERM_OUT_EN
    ,
    output logic [(1<<NIN)-1:0] mt_out
`endif
);

    localparam int unsigned NG = NIN / 2;
    localparam int unsigned NM = 1 << NIN;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NIN-1:0]      cnt_q, cnt_d;
    logic [NM-1:0]       shadow_q, shadow_d;
    logic [NM-1:0]       active_q, active_d;

    logic                s1_valid_q;
    logic [NG-1:0][3:0]  s1_dec_q, s1_dec_d;
    logic                s1_en_n_q;
    logic                s2_valid_q;
    logic                f_q;
    logic [NM-1:0]       mt_c;
    logic                f_c;
    logic                hit;

    logic                s1_adv;
    logic                s2_adv;
    logic                accept;

    // Handshake: a stage moves when it is empty or its successor moves.
    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = (state_q == ST_RUN) && s1_adv;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid_q;
    assign f_out     = f_q;
    assign cfg_busy  = (state_q != ST_RUN);

    // Stage-1 decode: each 2-bit group to a 4-line one-hot.
    always_comb begin
        s1_dec_d = '0;
        for (int g = 0; g < NG; g++) begin
            s1_dec_d[g] = 4'b0001 << in_vec[2*g +: 2];
        end
    end

    // Stage-2 AND-plane: minterm m is the AND of one line from every group.
    always_comb begin
        mt_c = '0;
        hit  = 1'b0;
        for (int m = 0; m < NM; m++) begin
            hit = 1'b1;
            for (int g = 0; g < NG; g++) begin
                hit = hit & s1_dec_q[g][2'((m >> (2*g)) & 3)];
            end
            mt_c[m] = hit & ~s1_en_n_q;
        end
        f_c = |(mt_c & active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_dec_q   <= '0;
            s1_en_n_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            f_q        <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_dec_q  <= s1_dec_d;
                    s1_en_n_q <= en_n;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    f_q <= f_c;
                end
            end
        end
    end

`ifdef MINTERM_OUT_EN
    logic [NM-1:0] mt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_q <= '0;
        end else if (s2_adv && s1_valid_q) begin
            mt_q <= mt_c;
        end
    end

    assign mt_out = mt_q;
`endif

    // Reload control: shadow fills serially, active swaps only once the pipe is empty.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        unique case (state_q)
            ST_RUN: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_bit_valid) begin
                    shadow_d = {shadow_q[NM-2:0], cfg_bit};
                    cnt_d    = cnt_q + NIN'(1);
                    if (cnt_q == NIN'(NM - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    active_d = shadow_q;
                    state_d  = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            shadow_q <= TT_INIT;
            active_q <= TT_INIT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

endmodule

// File: tb/tb_boolfn_dec_tree.sv
// Directed bench for boolfn_dec_tree with a result scoreboard and a reference truth-table model.
module tb_boolfn_dec_tree;

    localparam int unsigned NIN = 4;
    localparam int unsigned NM  = 16;

    logic           clk           = 1'b0;
    logic           rst_n         = 1'b0;
    logic           en_n          = 1'b0;
    logic           in_valid      = 1'b0;
    logic [NIN-1:0] in_vec        = '0;
    logic           out_ready     = 1'b1;
    logic           cfg_start     = 1'b0;
    logic           cfg_bit_valid = 1'b0;
    logic           cfg_bit       = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           f_out;
    logic           cfg_busy;
`ifdef MINTERM_OUT_EN
    logic [NM-1:0]  mt_out;
`endif

    boolfn_dec_tree #(.NIN(NIN), .TT_INIT(16'h0DE0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_n          (en_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vec        (in_vec),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .f_out         (f_out),
        .cfg_start     (cfg_start),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .cfg_busy      (cfg_busy)
`ifdef MINTERM_OUT_EN
        ,
        .mt_out        (mt_out)
`endif
    );

    typedef struct {
        logic          f;
        logic [NM-1:0] mt;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc      = 0;
    int            npass    = 0;
    int            ntot     = 0;
    bit            lat_chk  = 1'b0;
    bit            acc      = 1'b0;
    logic [NM-1:0] model_tt = 16'h0DE0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Output side: every delivered result is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("f_out", 32'(f_out), 32'(e.f));
`ifdef MINTERM_OUT_EN
                chk("mt_out", 32'(mt_out), 32'(e.mt));
`endif
                if (lat_chk) chk("latency", 32'(cyc - e.cyc), 2);
            end
        end
    end

    task automatic step();
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) begin
            e.f   = en_n ? 1'b0 : model_tt[in_vec];
            e.mt  = en_n ? '0 : (NM'(1) << in_vec);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NIN-1:0] v, input logic e);
        in_vec   = v;
        en_n     = e;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc) break;
        end
        chk("accepted", 32'(acc), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        chk("drained", sb.size(), 0);
    endtask

    task automatic cfg_pulse();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic shift(input logic [NM-1:0] p, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            cfg_bit       = p[NM-1-i];
            cfg_bit_valid = 1'b1;
            step();
            cfg_bit_valid = 1'b0;
            if (gaps && (i % 3 == 1)) step();
        end
    endtask

    initial begin
        int            idx;
        logic [NIN-1:0] sv[3];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_f_out", 32'(f_out), 0);
        chk("rst_cfg_busy", 32'(cfg_busy), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Back-to-back sweep of every minterm, then enable masking
        lat_chk = 1'b1;
        for (int v = 0; v < 16; v++) send(NIN'(v), 1'b0);
        send(4'b0101, 1'b1);
        send(4'b0101, 1'b0);
        drain();
        lat_chk = 1'b0;

        // Backpressure: only two results fit while the output is stalled
        sv = '{4'd6, 4'd9, 4'd10};
        idx       = 0;
        out_ready = 1'b0;
        in_vec    = sv[0];
        en_n      = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (acc) begin
                idx++;
                if (idx < 3) in_vec = sv[idx];
                else in_valid = 1'b0;
            end
        end
        chk("stall_accepts", 32'(idx), 2);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_f_hold", 32'(f_out), 32'(sb[0].f));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step();
            if (acc) begin
                idx++;
                in_valid = 1'b0;
            end
        end
        chk("stall_third_accept", 32'(idx), 3);
        drain();

        // Reload with two results held in flight
        out_ready = 1'b0;
        send(4'd5, 1'b0);
        send(4'd5, 1'b0);
        cfg_pulse();
        chk("load_busy", 32'(cfg_busy), 1);
        chk("load_in_ready", 32'(in_ready), 0);
        shift(16'h8001, 16, 1'b1);
        step();
        step();
        chk("commit_waits", 32'(cfg_busy), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!cfg_busy) break;
            step();
        end
        chk("busy_fall", 32'(cfg_busy), 0);
        drain();
        model_tt = 16'h8001;
        send(4'd0, 1'b0);
        send(4'd15, 1'b0);
        send(4'd5, 1'b0);
        drain();

        // Async reset in the middle of a load restores the default table
        out_ready = 1'b0;
        send(4'd0, 1'b0);
        step();
        step();
        cfg_pulse();
        shift(16'hFFFF, 7, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_cfg_busy", 32'(cfg_busy), 0);
        chk("arst_f_out", 32'(f_out), 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        model_tt  = 16'h0DE0;
        send(4'd5, 1'b0);
        send(4'd0, 1'b0);
        send(4'd15, 1'b0);
        send(4'd8, 1'b0);
        drain();

        // cfg_start during LOAD restarts the bit count
        cfg_pulse();
        shift(16'hFFFF, 10, 1'b0);
        cfg_pulse();
        shift(16'h00F0, 15, 1'b1);
        chk("restart_still_load", 32'(cfg_busy), 1);
        chk("restart_in_ready", 32'(in_ready), 0);
        cfg_bit       = 1'b0;
        cfg_bit_valid = 1'b1;
        step();
        cfg_bit_valid = 1'b0;
        chk("restart_commit", 32'(cfg_busy), 1);
        step();
        chk("restart_run", 32'(cfg_busy), 0);
        model_tt = 16'h00F0;
        send(4'd4, 1'b0);
        send(4'd8, 1'b0);
        send(4'd7, 1'b0);
        send(4'd11, 1'b0);
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
